mem_wb_stage: RTL and testbench

Back half of the 16-bit five-stage pipeline: holds the EX/MEM and MEM/WB pipeline registers, runs the data-memory request/acknowledge handshake with wait-state and timeout handling, and produces the forwarding selects and forwarded data consumed by the execute stage. It freezes the front of the pipeline while a memory access is outstanding, and drives the register-file write port.

---
 rtl/mem_wb_stage_if.sv | 21 ++
 rtl/mem_wb_stage.sv | 137 +++++++++++++
 tb/tb_mem_wb_stage.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// Data-memory port of the back half of the pipeline (EX/MEM -> memory -> MEM/WB).
// Handshake: the master holds Mem_Req high with Mem_We/Mem_Addr/Mem_WData stable until the
// slave raises Mem_Ack. Mem_RData is sampled in the Mem_Ack cycle. Mem_Ack while Mem_Req is low means nothing.
interface mem_wb_stage_if;
    logic        Mem_Req;
    logic        Mem_We;
    logic [15:0] Mem_Addr;
    logic [15:0] Mem_WData;
    logic [15:0] Mem_RData;
    logic        Mem_Ack;

    modport master (
        output Mem_Req, Mem_We, Mem_Addr, Mem_WData,
        input  Mem_RData, Mem_Ack
    );

    modport slave (
        input  Mem_Req, Mem_We, Mem_Addr, Mem_WData,
        output Mem_RData, Mem_Ack
    );
endinterface

// File: rtl/mem_wb_stage.sv
// EX/MEM and MEM/WB pipeline registers, data-memory access FSM with wait/timeout,
// forwarding selects for execute, and the register-file write port.
module mem_wb_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rest,
    input  logic [15:0]          Controll_Signals_In,
    input  logic [15:0]          AluResult_In,
    input  logic [15:0]          Read1_In,
    input  logic [3:0]           Rd_In,
    input  logic [3:0]           Rt_In,
    input  logic [3:0]           Src1_Reg,
    input  logic [3:0]           Src2_Reg,
    mem_wb_stage_if.master       mem,
    output logic                 MemStall,
    output logic                 Mem_Err,
    output logic [1:0]           ForwardA,
    output logic [1:0]           ForwardB,
    output logic [15:0]          EXMEMData,
    output logic [15:0]          MEMWBData,
    output logic                 WB_En,
    output logic [3:0]           WB_Reg,
    output logic [15:0]          WB_Data,
    output logic [1:0]           dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

    state_t      state_q;
    logic [7:0]  wait_cnt_q;
    logic        err_q;

    logic        exm_regwrite_q, exm_memtoreg_q, exm_memread_q, exm_memwrite_q;
    logic [15:0] exm_alu_q, exm_sdata_q;
    logic [3:0]  exm_dest_q;

    logic        wb_regwrite_q;
    logic [3:0]  wb_dest_q;
    logic [15:0] wb_data_q;

    logic        in_memop, memop, in_access, timed_out;
    logic [15:0] rdata;
    logic [3:0]  in_dest;

    wire unused_ctrl_bits = ^Controll_Signals_In[10:0];

    assign in_memop  = Controll_Signals_In[12] | Controll_Signals_In[11];
    assign in_dest   = Controll_Signals_In[13] ? Rd_In : Rt_In;
    assign memop     = exm_memread_q | exm_memwrite_q;
    assign in_access = (state_q == ACCESS);

    // An ack in the same cycle as the timeout wins: real data, no error.
    assign timed_out = in_access & ~mem.Mem_Ack & (wait_cnt_q >= TIMEOUT_C);
    assign MemStall  = in_access & ~mem.Mem_Ack & (wait_cnt_q < TIMEOUT_C);
    assign rdata     = (in_access & mem.Mem_Ack) ? mem.Mem_RData : 16'h0000;

    assign mem.Mem_Req   = memop & in_access;
    assign mem.Mem_We    = exm_memwrite_q;
    assign mem.Mem_Addr  = exm_alu_q;
    assign mem.Mem_WData = exm_sdata_q;

    assign EXMEMData   = exm_alu_q;
    assign MEMWBData   = wb_data_q;
    assign WB_En       = wb_regwrite_q;
    assign WB_Reg      = wb_dest_q;
    assign WB_Data     = wb_data_q;
    assign Mem_Err     = err_q;
    assign dbg_state_o = state_q;

    // Loads in EX/MEM never forward from EX/MEM; the hazard unit owns load-use.
    always_comb begin
        ForwardA = 2'b00;
        ForwardB = 2'b00;
        if (exm_regwrite_q && !exm_memtoreg_q && exm_dest_q == Src1_Reg) ForwardA = 2'b10;
        else if (wb_regwrite_q && wb_dest_q == Src1_Reg)                 ForwardA = 2'b01;
        if (exm_regwrite_q && !exm_memtoreg_q && exm_dest_q == Src2_Reg) ForwardB = 2'b10;
        else if (wb_regwrite_q && wb_dest_q == Src2_Reg)                 ForwardB = 2'b01;
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q        <= IDLE;
            wait_cnt_q     <= 8'd0;
            err_q          <= 1'b0;
            exm_regwrite_q <= 1'b0;
            exm_memtoreg_q <= 1'b0;
            exm_memread_q  <= 1'b0;
            exm_memwrite_q <= 1'b0;
            exm_alu_q      <= 16'h0000;
            exm_sdata_q    <= 16'h0000;
            exm_dest_q     <= 4'd0;
            wb_regwrite_q  <= 1'b0;
            wb_dest_q      <= 4'd0;
            wb_data_q      <= 16'h0000;
        end else begin
            if (!MemStall) begin
                exm_regwrite_q <= Controll_Signals_In[15];
                exm_memtoreg_q <= Controll_Signals_In[14];
                exm_memread_q  <= Controll_Signals_In[12];
                exm_memwrite_q <= Controll_Signals_In[11];
                exm_alu_q      <= AluResult_In;
                exm_sdata_q    <= Read1_In;
                exm_dest_q     <= in_dest;
                wb_regwrite_q  <= exm_regwrite_q;
                wb_dest_q      <= exm_dest_q;
                wb_data_q      <= exm_memtoreg_q ? rdata : exm_alu_q;
            end else begin
                wb_regwrite_q  <= 1'b0;
            end

            if (timed_out) err_q <= 1'b1;

            // DONE would only be held by an external freeze; with none, completion
            // hands straight over to the next instruction like IDLE does.
            case (state_q)
                ACCESS: begin
                    if (MemStall) begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end else begin
                        wait_cnt_q <= 8'd0;
                        state_q    <= in_memop ? ACCESS : IDLE;
                    end
                end
                default: begin
                    wait_cnt_q <= 8'd0;
                    state_q    <= in_memop ? ACCESS : IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus random instruction streams, checked
// against an instruction-level model of the memory stage and write-back/forwarding results.
module tb_mem_wb_stage;
    localparam int TIMEOUT = 15;

    typedef struct {
        logic        rw, m2r, rdst, mrd, mwr;
        logic [10:0] junk;
        logic [15:0] alu, sdata, rdata;
        logic [3:0]  rd, rt;
        int          k;
    } instr_t;

    logic        clk, rest;
    logic [15:0] Controll_Signals_In, AluResult_In, Read1_In;
    logic [3:0]  Rd_In, Rt_In, Src1_Reg, Src2_Reg;
    logic        MemStall, Mem_Err, WB_En;
    logic [1:0]  ForwardA, ForwardB, dbg_state;
    logic [15:0] EXMEMData, MEMWBData, WB_Data;
    logic [3:0]  WB_Reg;

    mem_wb_stage_if mif ();

    mem_wb_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rest(rest),
        .Controll_Signals_In(Controll_Signals_In), .AluResult_In(AluResult_In),
        .Read1_In(Read1_In), .Rd_In(Rd_In), .Rt_In(Rt_In),
        .Src1_Reg(Src1_Reg), .Src2_Reg(Src2_Reg), .mem(mif),
        .MemStall(MemStall), .Mem_Err(Mem_Err), .ForwardA(ForwardA), .ForwardB(ForwardB),
        .EXMEMData(EXMEMData), .MEMWBData(MEMWBData), .WB_En(WB_En), .WB_Reg(WB_Reg),
        .WB_Data(WB_Data), .dbg_state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int force_src = -1;

    // Model: instruction currently in EX/MEM, plus architectural write-back state.
    instr_t      ex_m;
    logic        wb_en_m, err_m;
    logic [3:0]  wb_reg_m;
    logic [15:0] wb_data_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic instr_t mk(input logic [15:0] ctrl, input logic [15:0] alu,
                                  input logic [15:0] sdata, input logic [15:0] rdata,
                                  input logic [3:0] rd, input logic [3:0] rt, input int k);
        instr_t x;
        x.rw = ctrl[15]; x.m2r = ctrl[14]; x.rdst = ctrl[13]; x.mrd = ctrl[12]; x.mwr = ctrl[11];
        x.junk = ctrl[10:0];
        x.alu = alu; x.sdata = sdata; x.rdata = rdata; x.rd = rd; x.rt = rt; x.k = k;
        return x;
    endfunction

    function automatic instr_t rand_instr();
        instr_t x;
        int op;
        op     = int'($urandom_range(0, 3));
        x.rw   = 1'($urandom_range(0, 1));
        x.rdst = 1'($urandom_range(0, 1));
        x.mrd  = (op == 1);
        x.mwr  = (op == 2);
        x.m2r  = x.mrd ? 1'($urandom_range(0, 1)) : 1'b0;
        x.junk = 11'($urandom);
        x.alu  = 16'($urandom); x.sdata = 16'($urandom); x.rdata = 16'($urandom);
        x.rd   = 4'($urandom_range(0, 7)); x.rt = 4'($urandom_range(0, 7));
        x.k    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TIMEOUT - 1, TIMEOUT + 2))
                                             : int'($urandom_range(0, 3));
        return x;
    endfunction

    function automatic logic [3:0] dest_of(input instr_t x);
        return x.rdst ? x.rd : x.rt;
    endfunction

    function automatic logic [1:0] fwd_exp(input logic [3:0] s);
        if (ex_m.rw && !ex_m.m2r && dest_of(ex_m) == s) return 2'b10;
        if (wb_en_m && wb_reg_m == s) return 2'b01;
        return 2'b00;
    endfunction

    task automatic drive_ex(input instr_t x);
        Controll_Signals_In = {x.rw, x.m2r, x.rdst, x.mrd, x.mwr, x.junk};
        AluResult_In = x.alu; Read1_In = x.sdata; Rd_In = x.rd; Rt_In = x.rt;
    endtask

    task automatic drive_junk();
        Controll_Signals_In = 16'($urandom); AluResult_In = 16'($urandom);
        Read1_In = 16'($urandom); Rd_In = 4'($urandom); Rt_In = 4'($urandom);
        Src1_Reg = 4'($urandom); Src2_Reg = 4'($urandom);
        mif.Mem_Ack = 1'($urandom_range(0, 1)); mif.Mem_RData = 16'($urandom);
    endtask

    task automatic model_reset();
        ex_m = mk(16'h0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0, 0);
        wb_en_m = 1'b0; wb_reg_m = 4'd0; wb_data_m = 16'h0; err_m = 1'b0;
    endtask

    // Run the memory stage of ex_m to completion; nxt is offered on the EX inputs in its final cycle.
    task automatic step_instr(input instr_t nxt);
        logic memop, last, tmo;
        int len;
        logic [3:0] s1, s2;
        memop = ex_m.mrd | ex_m.mwr;
        len   = memop ? (((ex_m.k < TIMEOUT) ? ex_m.k : TIMEOUT) + 1) : 1;
        tmo   = memop && (ex_m.k > TIMEOUT);
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            last = (c == len - 1);
            drive_junk();
            if (last) drive_ex(nxt);
            s1 = (force_src >= 0) ? 4'(force_src) : 4'($urandom_range(0, 7));
            s2 = (force_src >= 0) ? 4'(force_src) : 4'($urandom_range(0, 7));
            Src1_Reg = s1; Src2_Reg = s2;
            if (memop) begin
                mif.Mem_Ack = (c == ex_m.k);
                if (c == ex_m.k) mif.Mem_RData = ex_m.rdata;
            end
            #1;
            chk("mem_req", 32'(mif.Mem_Req), 32'(memop));
            chk("mem_stall", 32'(MemStall), 32'(memop && !last));
            if (memop) begin
                chk("mem_we", 32'(mif.Mem_We), 32'(ex_m.mwr));
                chk("mem_addr", 32'(mif.Mem_Addr), 32'(ex_m.alu));
                chk("mem_wdata", 32'(mif.Mem_WData), 32'(ex_m.sdata));
            end
            chk("wb_en", 32'(WB_En), 32'(wb_en_m));
            chk("wb_reg", 32'(WB_Reg), 32'(wb_reg_m));
            chk("wb_data", 32'(WB_Data), 32'(wb_data_m));
            chk("memwb_data", 32'(MEMWBData), 32'(wb_data_m));
            chk("exmem_data", 32'(EXMEMData), 32'(ex_m.alu));
            chk("mem_err", 32'(Mem_Err), 32'(err_m));
            chk("fwd_a", 32'(ForwardA), 32'(fwd_exp(s1)));
            chk("fwd_b", 32'(ForwardB), 32'(fwd_exp(s2)));
            if (last) begin
                wb_en_m   = ex_m.rw;
                wb_reg_m  = dest_of(ex_m);
                wb_data_m = ex_m.m2r ? ((memop && !tmo) ? ex_m.rdata : 16'h0000) : ex_m.alu;
                if (tmo) err_m = 1'b1;
            end else begin
                wb_en_m = 1'b0;
            end
        end
        ex_m = nxt;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, 32'(mif.Mem_Req), 32'd0);
        chk({tag, "_we"}, 32'(mif.Mem_We), 32'd0);
        chk({tag, "_addr"}, 32'(mif.Mem_Addr), 32'd0);
        chk({tag, "_wdata"}, 32'(mif.Mem_WData), 32'd0);
        chk({tag, "_stall"}, 32'(MemStall), 32'd0);
        chk({tag, "_err"}, 32'(Mem_Err), 32'd0);
        chk({tag, "_fwd"}, 32'({ForwardA, ForwardB}), 32'd0);
        chk({tag, "_exmem"}, 32'(EXMEMData), 32'd0);
        chk({tag, "_memwb"}, 32'(MEMWBData), 32'd0);
        chk({tag, "_wb"}, 32'({WB_En, WB_Reg, WB_Data}), 32'd0);
    endtask

    instr_t nop, a, b;

    initial begin
        nop = mk(16'h0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0, 0);

        // Reset with random inputs: every output must read zero.
        rest = 1'b0;
        drive_junk();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_junk();
            #1;
            chk_all_zero("reset");
        end
        @(negedge clk);
        drive_ex(nop);
        rest = 1'b1;
        model_reset();

        // First ALU instruction after reset: ctrl 0x8000, alu 0x1234, Rt 3.
        step_instr(mk(16'h8000, 16'h1234, 16'h0, 16'h0, 4'd9, 4'd3, 0));
        step_instr(nop);
        step_instr(nop);

        // Zero-wait load.
        step_instr(mk(16'hD000, 16'h0040, 16'h0, 16'hBEEF, 4'd0, 4'd6, 0));
        step_instr(nop);
        // Wait-state store with ack after three wait cycles.
        step_instr(mk(16'h0800, 16'h0300, 16'h5A5A, 16'h0, 4'd0, 4'd1, 3));
        step_instr(nop);
        // Ack arriving exactly at the timeout cycle: real data, no error.
        step_instr(mk(16'hD000, 16'h0050, 16'h0, 16'hCAFE, 4'd0, 4'd7, TIMEOUT));
        step_instr(nop);
        // Timeout: load never acknowledged.
        step_instr(mk(16'hD000, 16'h0060, 16'h0, 16'h9999, 4'd0, 4'd4, 99));
        step_instr(nop);
        step_instr(nop);

        // Forwarding priority: EX/MEM ALU result beats MEM/WB, a load in EX/MEM does not.
        force_src = 5;
        a = mk(16'hA000, 16'h2222, 16'h0, 16'h0, 4'd5, 4'd0, 0);
        b = mk(16'hA000, 16'h1111, 16'h0, 16'h0, 4'd5, 4'd0, 0);
        step_instr(a);
        step_instr(b);
        step_instr(nop);
        step_instr(a);
        step_instr(mk(16'hF000, 16'h1111, 16'h0, 16'h3333, 4'd5, 4'd0, 0));
        step_instr(nop);
        step_instr(nop);
        force_src = -1;

        // Reset in the second wait cycle of a load.
        step_instr(mk(16'hD000, 16'h0100, 16'h0, 16'h7777, 4'd0, 4'd2, 99));
        @(negedge clk);
        drive_junk();
        mif.Mem_Ack = 1'b0;
        #1;
        chk("midrst_req_w1", 32'(mif.Mem_Req), 32'd1);
        chk("midrst_stall_w1", 32'(MemStall), 32'd1);
        @(negedge clk);
        drive_junk();
        mif.Mem_Ack = 1'b0;
        #1;
        chk("midrst_stall_w2", 32'(MemStall), 32'd1);
        rest = 1'b0;
        #1;
        chk("midrst_req_drop", 32'(mif.Mem_Req), 32'd0);
        chk("midrst_stall_drop", 32'(MemStall), 32'd0);
        @(negedge clk);
        drive_ex(nop);
        rest = 1'b1;
        #1;
        chk("midrst_state", 32'(dbg_state), 32'd0);
        chk("midrst_err", 32'(Mem_Err), 32'd0);
        model_reset();

        // Random instruction stream.
        for (int i = 0; i < 60; i++) step_instr(rand_instr());
        step_instr(nop);
        step_instr(nop);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
